instruction_cache: RTL and testbench
====================================

# instruction_cache

Direct-mapped instruction cache for the 32-bit RISC fetch stage, sitting directly downstream of the PC register. It takes the PC's `ADDRESS`, returns the instruction word combinationally on a hit, and drives `HIT`, which the PC uses as its advance enable. On a miss it holds `HIT` low, refills the whole line from instruction memory over a request/acknowledge handshake, and then serves the hit.

## Interface

Parameters:
- `LINES`, default 16: number of cache lines; power of two, ≥2.
- `WORDS_PER_LINE`, default 4: 32-bit words per line; power of two, ≥2.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `ADDRESS`  in  32  — byte fetch address from the PC; bits [1:0] are ignored.
- `INSTRUCTION`  out  32  — cached word at `ADDRESS`; 0 whenever `HIT`=0.
- `HIT`  out  1  — 1 when `ADDRESS` is resident and the block is in IDLE; the PC advances only when this is 1.
- `MEM_REQ`  out  1  — refill word request to instruction memory.
- `MEM_ADDR`  out  32  — word-aligned byte address of the requested word.
- `MEM_ACK`  in  1  — memory has `MEM_DATA` valid for the current request.
- `MEM_DATA`  in  32  — returned word; sampled only when `MEM_REQ`=1 and `MEM_ACK`=1.

## Operation

- Address split:
  - offset = `ADDRESS[OFF_W+1:2]`, with OFF_W = log2(`WORDS_PER_LINE`).
  - index = next IDX_W bits, with IDX_W = log2(`LINES`).
  - tag = remaining upper bits, TAG_W = 30 − OFF_W − IDX_W.
- Storage:
  - per line: `valid` bit and tag.
  - data array of `LINES`×`WORDS_PER_LINE` words.
- States: IDLE and FILL.
- IDLE:
  - `HIT` = valid[index] & (tag[index] == tag).
  - `INSTRUCTION` = data[index][offset] when `HIT`, else 0.
  - On a miss, the next edge:
    - latches line base (`ADDRESS` with offset and byte bits zeroed);
    - clears valid[index];
    - clears the word counter;
    - moves to FILL.
- FILL:
  - `HIT`=0 and `MEM_REQ`=1.
  - `MEM_ADDR` = base + 4·counter.
  - On each edge with `MEM_ACK`=1: writes `MEM_DATA` to data[base index][counter] and increments the counter.
  - The edge accepting the last word (counter = `WORDS_PER_LINE`−1) writes tag, sets valid, and returns to IDLE.
- Handshake:
  - `MEM_ADDR` is stable while `MEM_REQ`=1 and `MEM_ACK`=0.
  - Back-to-back acks are allowed: `MEM_REQ` stays high and the address advances the cycle after each ack.
  - `MEM_ACK` while `MEM_REQ`=0 is ignored.
- A fill always completes for the latched line, even if `ADDRESS` changes during FILL. The PC holds, so it does not change in normal use.
- Lines are never written in IDLE. There is no invalidate and no write path from the core.

## Timing

- Reset (async assert, release synchronous to `clk`):
  - state IDLE; all valid bits 0; counter 0.
  - `HIT`=0, `INSTRUCTION`=0, `MEM_REQ`=0, `MEM_ADDR`=0.
  - Data and tag arrays need not be reset.
- Hit latency: 0 cycles. `HIT`/`INSTRUCTION` are combinational from `ADDRESS` in IDLE.
- Miss, address A presented in cycle t:
  - `MEM_REQ`=1 from t+1.
  - With a zero-wait memory (ack in the same cycle as the request), acks land in t+1…t+`WORDS_PER_LINE`.
  - IDLE and `HIT`=1 for A at t+`WORDS_PER_LINE`+1, giving a penalty of `WORDS_PER_LINE`+1 cycles.
  - Each memory wait cycle adds one cycle.
- `rst` asserted mid-FILL:
  - immediate return to the IDLE/reset values;
  - the partially filled line stays invalid, so it never produces a false hit.
- Index wrap: addresses differing only in tag map to the same line; a refill evicts the older tag.
- Address wrap: `MEM_ADDR` never crosses the line, so base + 4·(`WORDS_PER_LINE`−1) ≤ 0xFFFFFFFC always holds.

## Structure

- Package `icache_pkg`:
  - state encoding constants IDLE/FILL;
  - width functions/constants OFF_W, IDX_W, TAG_W derived from the parameters.
- Sub-module `icache_data_ram`:
  - `LINES`·`WORDS_PER_LINE`×32 array;
  - one synchronous write port (line, word, data, we);
  - one asynchronous read port.
- Tag/valid arrays, FSM and counter live in `instruction_cache`.

## Test plan

- **Cold miss and fill:** reset, `ADDRESS`=0x00000000, zero-wait memory returning `MEM_DATA`=0x1000+addr.
  - `MEM_ADDR` = 0x0, 0x4, 0x8, 0xC in successive cycles.
  - `HIT`=1 in cycle 5 with `INSTRUCTION`=0x1000.
- **Hits within a line:** after that fill, `ADDRESS` 0x4, 0x8, 0xC.
  - `HIT`=1 immediately, `INSTRUCTION` = 0x1004, 0x1008, 0x100C.
  - `MEM_REQ` stays 0.
- **Wait states:** `MEM_ACK` delayed 2 cycles per word on a miss at 0x40.
  - `MEM_ADDR` is held stable through the wait cycles.
  - `HIT` rises 13 cycles after the miss.
- **Conflict eviction:** fill 0x000, then access 0x100 (same index, different tag).
  - Miss, refill, `INSTRUCTION`=0x1100.
  - Re-access 0x000 misses again.
- **Reset mid-fill:** assert `rst` after 2 acks of a fill at 0x80.
  - `MEM_REQ`=0 immediately.
  - After release, 0x80 misses and refills all 4 words.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared state encoding and address-split width helpers for the instruction cache.
package icache_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  function automatic int unsigned off_w(input int unsigned words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int unsigned idx_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  // Word-aligned addresses leave 30 bits to split between tag, index and offset.
  function automatic int unsigned tag_w(input int unsigned lines, input int unsigned words_per_line);
    return 30 - off_w(words_per_line) - idx_w(lines);
  endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Cache data array: one synchronous write port, one asynchronous read port.
module icache_data_ram
  import icache_pkg::*;
#(
  parameter int unsigned LINES          = 16,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned IDX_W          = idx_w(LINES),
  parameter int unsigned OFF_W          = off_w(WORDS_PER_LINE)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_line_i,
  input  logic [OFF_W-1:0] wr_word_i,
  input  logic [31:0]      wr_data_i,
  input  logic [IDX_W-1:0] rd_line_i,
  input  logic [OFF_W-1:0] rd_word_i,
  output logic [31:0]      rd_data_o
);

  logic [31:0] mem_q [LINES*WORDS_PER_LINE];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[{wr_line_i, wr_word_i}] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[{rd_line_i, rd_word_i}];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache: combinational hit path, whole-line refill on a miss.
module instruction_cache
  import icache_pkg::*;
#(
  parameter int unsigned LINES          = 16,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ADDRESS,
  output logic [31:0] INSTRUCTION,
  output logic        HIT,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_DATA
);

  localparam int unsigned OFF_W  = off_w(WORDS_PER_LINE);
  localparam int unsigned IDX_W  = idx_w(LINES);
  localparam int unsigned TAG_W  = tag_w(LINES, WORDS_PER_LINE);
  localparam int unsigned LINE_W = TAG_W + IDX_W;

  logic [OFF_W-1:0] addr_off;
  logic [IDX_W-1:0] addr_idx;
  logic [TAG_W-1:0] addr_tag;
  logic [1:0]       unused_addr_bits;

  assign addr_off         = ADDRESS[OFF_W+1:2];
  assign addr_idx         = ADDRESS[OFF_W+2 +: IDX_W];
  assign addr_tag         = ADDRESS[31 -: TAG_W];
  assign unused_addr_bits = ADDRESS[1:0];

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] base_q, base_d;
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q [LINES];

  logic [IDX_W-1:0] base_idx;
  logic [TAG_W-1:0] base_tag;
  logic             we;
  logic             clr_valid;
  logic             set_valid;
  logic [31:0]      rd_data;

  assign base_idx = base_q[IDX_W-1:0];
  assign base_tag = base_q[LINE_W-1 -: TAG_W];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    HIT       = 1'b0;
    MEM_REQ   = 1'b0;
    MEM_ADDR  = 32'h0;
    we        = 1'b0;
    clr_valid = 1'b0;
    set_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        HIT = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
        if (!HIT) begin
          base_d    = ADDRESS[31:OFF_W+2];
          cnt_d     = '0;
          clr_valid = 1'b1;
          state_d   = FILL;
        end
      end
      FILL: begin
        MEM_REQ  = 1'b1;
        MEM_ADDR = {base_q, cnt_q, 2'b00};
        if (MEM_ACK) begin
          we    = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == OFF_W'(WORDS_PER_LINE - 1)) begin
            set_valid = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      if (clr_valid) begin
        valid_q[addr_idx] <= 1'b0;
      end else if (set_valid) begin
        valid_q[base_idx] <= 1'b1;
      end
    end
  end

  // Tags are only trusted behind valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (set_valid) begin
      tag_q[base_idx] <= base_tag;
    end
  end

  icache_data_ram #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .IDX_W          (IDX_W),
    .OFF_W          (OFF_W)
  ) u_data_ram (
    .clk_i     (clk),
    .we_i      (we),
    .wr_line_i (base_idx),
    .wr_word_i (cnt_q),
    .wr_data_i (MEM_DATA),
    .rd_line_i (addr_idx),
    .rd_word_i (addr_off),
    .rd_data_o (rd_data)
  );

  assign INSTRUCTION = HIT ? rd_data : 32'h0;

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache with a small configurable-latency memory model.
module tb_instruction_cache;

  logic        clk;
  logic        rst;
  logic [31:0] address;
  logic [31:0] instruction;
  logic        hit;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;

  int total;
  int bad;

  int wait_target;
  int wcnt;
  logic ack_always;

  instruction_cache #(
    .LINES          (16),
    .WORDS_PER_LINE (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ADDRESS     (address),
    .INSTRUCTION (instruction),
    .HIT         (hit),
    .MEM_REQ     (mem_req),
    .MEM_ADDR    (mem_addr),
    .MEM_ACK     (mem_ack),
    .MEM_DATA    (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: word at byte address a holds 0x1000 + a; ack after wait_target wait cycles.
  assign mem_data = 32'h1000 + mem_addr;
  assign mem_ack  = ack_always || (mem_req && (wcnt >= wait_target));

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Presents a missing address at a negedge, follows the refill, checks latency and data.
  task automatic run_miss(input logic [31:0] a, input int wait_n, input int exp_lat,
                          input string name);
    int acks;
    int n;
    logic [31:0] base;
    wait_target = wait_n;
    base        = a & ~32'hF;
    address     = a;
    #1;
    check({name, "_miss"}, {31'b0, hit}, 32'h0);
    check({name, "_miss_instr"}, instruction, 32'h0);
    acks = 0;
    n    = 1;
    while (n <= 60) begin
      @(negedge clk);
      if (hit) break;
      check({name, "_req"}, {31'b0, mem_req}, 32'h1);
      check({name, "_addr"}, mem_addr, base + 32'(4 * acks));
      if (mem_ack) acks++;
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'(exp_lat));
    check({name, "_data"}, instruction, 32'h1000 + a);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        exp_hit;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs [7];

  initial begin
    total       = 0;
    bad         = 0;
    wait_target = 0;
    ack_always  = 1'b0;
    wcnt        = 0;
    address     = 32'h0;
    rst         = 1'b1;

    vecs[0] = '{32'h0000_0004, 1'b1, 32'h0000_1004};
    vecs[1] = '{32'h0000_0008, 1'b1, 32'h0000_1008};
    vecs[2] = '{32'h0000_000C, 1'b1, 32'h0000_100C};
    vecs[3] = '{32'h0000_0002, 1'b1, 32'h0000_1000};
    vecs[4] = '{32'h0000_0010, 1'b0, 32'h0000_0000};
    vecs[5] = '{32'h0000_0100, 1'b0, 32'h0000_0000};
    vecs[6] = '{32'hFFFF_FFF0, 1'b0, 32'h0000_0000};

    @(negedge clk);
    check("rst_hit", {31'b0, hit}, 32'h0);
    check("rst_instr", instruction, 32'h0);
    check("rst_req", {31'b0, mem_req}, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    rst = 1'b0;

    run_miss(32'h0, 0, 5, "cold");

    // Hits and misses probed combinationally, then parked back on a resident address.
    for (int i = 0; i < 7; i++) begin
      address = vecs[i].addr;
      #1;
      check($sformatf("vec%0d_hit", i), {31'b0, hit}, {31'b0, vecs[i].exp_hit});
      check($sformatf("vec%0d_instr", i), instruction, vecs[i].exp_instr);
      check($sformatf("vec%0d_req", i), {31'b0, mem_req}, 32'h0);
      address = 32'h0;
      @(negedge clk);
    end

    run_miss(32'h40, 2, 13, "wait");

    run_miss(32'h100, 0, 5, "evict");
    run_miss(32'h0, 0, 5, "refetch");
    address = 32'h44;
    #1;
    check("other_line_hit", {31'b0, hit}, 32'h1);
    check("other_line_data", instruction, 32'h1044);

    address    = 32'h0;
    ack_always = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_ack_hit", {31'b0, hit}, 32'h1);
      check("idle_ack_req", {31'b0, mem_req}, 32'h0);
      check("idle_ack_data", instruction, 32'h1000);
    end
    ack_always = 1'b0;

    // Reset after two acks of a fill at 0x80.
    wait_target = 0;
    address     = 32'h80;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("midfill_addr", mem_addr, 32'h88);
    rst = 1'b1;
    #1;
    check("midfill_rst_req", {31'b0, mem_req}, 32'h0);
    check("midfill_rst_hit", {31'b0, hit}, 32'h0);
    check("midfill_rst_addr", mem_addr, 32'h0);
    check("midfill_rst_instr", instruction, 32'h0);
    @(negedge clk);
    rst     = 1'b0;
    address = 32'h0;
    #1;
    check("post_rst_line0_invalid", {31'b0, hit}, 32'h0);
    run_miss(32'h80, 0, 5, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
